// File: rtl/mac_pkg.sv
// Shared types and fixed-point format constants for the MAC sequencer.
package mac_pkg;

  localparam int WIDTH_INPUT  = 16;
  localparam int WIDTH_OUTPUT = 32;
  localparam int WIDTH_ACC    = 40;
  localparam int WIDTH_LEN    = 8;

  // Operands are Q6.9, products and results Q12.18
  localparam int FRAC_IN  = 9;
  localparam int FRAC_OUT = 18;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mac_state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, multiplier and result signals of the MAC sequencer.
interface mac_seq_ctrl_if;
  import mac_pkg::*;

  logic                    start_i;
  logic [WIDTH_LEN-1:0]    len_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [WIDTH_INPUT-1:0]  a_i;
  logic [WIDTH_INPUT-1:0]  b_i;
  logic [WIDTH_INPUT-1:0]  mul_a_o;
  logic [WIDTH_INPUT-1:0]  mul_b_o;
  logic [WIDTH_OUTPUT-1:0] mul_p_i;
  logic [WIDTH_OUTPUT-1:0] result_o;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic                    busy_o;

  modport slave (
    input  start_i, len_i, in_valid_i, a_i, b_i, mul_p_i, result_ready_i,
    output in_ready_o, mul_a_o, mul_b_o, result_o, result_valid_o, busy_o
  );

  modport master (
    output start_i, len_i, in_valid_i, a_i, b_i, mul_p_i, result_ready_i,
    input  in_ready_o, mul_a_o, mul_b_o, result_o, result_valid_o, busy_o
  );

endinterface

// File: rtl/mac_sat_trunc.sv
// Narrows the accumulator to the result width: clamps when MAC_SAT_EN is
// defined, otherwise plain two's-complement truncation.
module mac_sat_trunc
  import mac_pkg::*;
(
  input  logic [WIDTH_ACC-1:0]    acc_i,
  output logic [WIDTH_OUTPUT-1:0] res_o
);

`ifdef MAC_SAT_EN
  logic in_range;

  // In range exactly when all bits above the result sign bit match it
  assign in_range = (acc_i[WIDTH_ACC-1:WIDTH_OUTPUT-1] == '0) ||
                    (&acc_i[WIDTH_ACC-1:WIDTH_OUTPUT-1]);

  always_comb begin
    res_o = acc_i[WIDTH_OUTPUT-1:0];
    if (!in_range) begin
      if (acc_i[WIDTH_ACC-1]) res_o = {1'b1, {(WIDTH_OUTPUT-1){1'b0}}};
      else                    res_o = {1'b0, {(WIDTH_OUTPUT-1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^acc_i[WIDTH_ACC-1:WIDTH_OUTPUT];
  assign res_o     = acc_i[WIDTH_OUTPUT-1:0];
`endif

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer driving an external signed multiplier.
// Optional result saturation is enabled with MAC_SAT_EN.
module mac_seq_ctrl
  import mac_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  mac_seq_ctrl_if.slave bus
);

  mac_state_e              state_q, state_d;
  logic [WIDTH_LEN-1:0]    cnt_q, cnt_d;
  logic [WIDTH_INPUT-1:0]  mul_a_q, mul_a_d;
  logic [WIDTH_INPUT-1:0]  mul_b_q, mul_b_d;
  logic                    v1_q, v1_d;
  logic [WIDTH_OUTPUT-1:0] p_q, p_d;
  logic                    v2_q, v2_d;
  logic [WIDTH_ACC-1:0]    acc_q, acc_d;
  logic                    in_ready_q, in_ready_d;
  logic                    result_valid_q, result_valid_d;
  logic                    busy_q, busy_d;
  logic                    hs;

  assign hs = (state_q == RUN) && in_ready_q && bus.in_valid_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    v1_d    = 1'b0;
    p_d     = p_q;
    v2_d    = v1_q;
    acc_d   = acc_q;

    // Two-stage pipeline: operands -> registered product -> accumulator
    if (v1_q) p_d = bus.mul_p_i;
    if (v2_q) acc_d = acc_q + {{(WIDTH_ACC-WIDTH_OUTPUT){p_q[WIDTH_OUTPUT-1]}}, p_q};

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          acc_d   = '0;
          cnt_d   = bus.len_i;
          state_d = (bus.len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (hs) begin
          mul_a_d = bus.a_i;
          mul_b_d = bus.b_i;
          v1_d    = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == WIDTH_LEN'(1)) state_d = DRAIN;
        end
      end
      // Leave once the last product has moved to the adder stage
      DRAIN: begin
        if (!v1_q) state_d = DONE;
      end
      DONE: begin
        if (bus.result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d     = (state_d == RUN);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      v1_q           <= 1'b0;
      p_q            <= '0;
      v2_q           <= 1'b0;
      acc_q          <= '0;
      in_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      v1_q           <= v1_d;
      p_q            <= p_d;
      v2_q           <= v2_d;
      acc_q          <= acc_d;
      in_ready_q     <= in_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  mac_sat_trunc u_sat_trunc (
    .acc_i (acc_q),
    .res_o (bus.result_o)
  );

  assign bus.mul_a_o        = mul_a_q;
  assign bus.mul_b_o        = mul_b_q;
  assign bus.in_ready_o     = in_ready_q;
  assign bus.result_valid_o = result_valid_q;
  assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: a dot-product model feeds an expected
// queue, a negedge monitor checks every presented result and its latency.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mac_seq_ctrl_if bus ();

  mac_seq_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // External multiplier: plain signed 16x16 -> 32
  logic signed [31:0] ext_a, ext_b;
  assign ext_a       = {{16{bus.mul_a_o[15]}}, bus.mul_a_o};
  assign ext_b       = {{16{bus.mul_b_o[15]}}, bus.mul_b_o};
  assign bus.mul_p_i = ext_a * ext_b;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  shortint     pa[256];
  shortint     pb[256];
  int          cyc = 0;
  int          last_evt = 0;
  int          evt_lat = 0;
  logic        prev_valid = 1'b0;
  bit          rdy_force = 1'b0;
  logic        rdy_val = 1'b0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Dot product of the first n pairs, wrapped to 40 bits, then narrowed
  function automatic logic [31:0] model(input int n);
    longint sum = 0;
    longint w;
    logic [63:0] wb;
    for (int i = 0; i < n; i++) sum += longint'(pa[i]) * longint'(pb[i]);
    w = (sum <<< 24) >>> 24;
`ifdef MAC_SAT_EN
    if (w > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (w < -64'sd2147483648) return 32'h80000000;
`endif
    wb = w;
    return wb[31:0];
  endfunction

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_in_ready"},     bus.in_ready_o,     0);
    checkOutput({tag, "_result_valid"}, bus.result_valid_o, 0);
    checkOutput({tag, "_busy"},         bus.busy_o,         0);
    checkOutput({tag, "_mul_a"},        bus.mul_a_o,        0);
    checkOutput({tag, "_mul_b"},        bus.mul_b_o,        0);
    checkOutput({tag, "_result"},       bus.result_o,       0);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (bus.busy_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    checkOutput("return_to_idle", bus.busy_o, 0);
  endtask

  // Issue a len-n command and send n_send pairs with gaps in [gmin,gmax];
  // optionally pulse a len=5 start mid-stream, which must be ignored.
  task automatic applyStimulus(input int n, input int n_send, input int gmin,
                               input int gmax, input bit inject);
    if (n_send == n) exp_q.push_back(model(n));
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.len_i   = 8'(n);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.len_i   = 8'($urandom_range(0, 255));
    for (int i = 0; i < n_send; i++) begin
      int g;
      int t;
      g = $urandom_range(gmin, gmax);
      if (inject && i == 1 && g == 0) g = 1;
      for (int k = 0; k < g; k++) begin
        bus.in_valid_i = 1'b0;
        bus.a_i        = 16'($urandom);
        bus.b_i        = 16'($urandom);
        bus.start_i    = (inject && i == 1 && k == 0);
        bus.len_i      = bus.start_i ? 8'd5 : bus.len_i;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
      end
      bus.in_valid_i = 1'b1;
      bus.a_i        = pa[i];
      bus.b_i        = pb[i];
      t = 0;
      @(negedge clk);
      while (!bus.in_ready_o && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!bus.in_ready_o) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL in_ready_timeout: pair %0d not accepted, in_ready=%0b required 1", i, bus.in_ready_o);
      end
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
    bus.a_i        = 16'($urandom);
    bus.b_i        = 16'($urandom);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    bus.result_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_force) bus.result_ready_i = rdy_val;
      else           bus.result_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency of each rising result_valid, value of every valid cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.in_valid_i && bus.in_ready_o) begin
          last_evt = cyc + 1;
          evt_lat  = 2;
        end
        if (!bus.busy_o && bus.start_i && bus.len_i == 8'd0) begin
          last_evt = cyc + 1;
          evt_lat  = 0;
        end
        if (bus.result_valid_o) begin
          if (!prev_valid) checkOutput("result_latency", cyc - last_evt, evt_lat);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL unexpected_result: got 0x%0h, required no result", bus.result_o);
          end else begin
            checkOutput("result", bus.result_o, exp_q[0]);
            checkOutput("busy_while_valid", bus.busy_o, 1);
            if (bus.result_ready_i) void'(exp_q.pop_front());
          end
        end
        prev_valid = bus.result_valid_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.start_i    = 1'b0;
    bus.len_i      = '0;
    bus.in_valid_i = 1'b0;
    bus.a_i        = '0;
    bus.b_i        = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] len=3 back-to-back 1.0*1.0");
    for (int i = 0; i < 3; i++) begin pa[i] = 16'h0200; pb[i] = 16'h0200; end
    applyStimulus(3, 3, 0, 0, 1'b0);
    wait_idle();

    $display("[TB] len=2 with 2-cycle gaps");
    pa[0] = 16'h0200; pb[0] = 16'hFE00;
    pa[1] = 16'h0400; pb[1] = 16'h0200;
    applyStimulus(2, 2, 2, 2, 1'b0);
    wait_idle();

    $display("[TB] len=0 with result held");
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    applyStimulus(0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("len0_no_in_ready", bus.in_ready_o, 0);
      checkOutput("len0_valid_held", bus.result_valid_o, 1);
    end
    rdy_val = 1'b1;
    wait_idle();
    rdy_force = 1'b0;

    $display("[TB] len=2 overflow of result width");
    for (int i = 0; i < 2; i++) begin pa[i] = 16'h8000; pb[i] = 16'h8000; end
    applyStimulus(2, 2, 0, 0, 1'b0);
    wait_idle();

    $display("[TB] reset in the middle of a len=4 command");
    for (int i = 0; i < 4; i++) begin pa[i] = 16'($urandom); pb[i] = 16'($urandom); end
    applyStimulus(4, 2, 0, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pa[0] = 16'h0200; pb[0] = 16'h0200;
    applyStimulus(1, 1, 0, 1, 1'b0);
    wait_idle();

    $display("[TB] start pulsed during RUN is ignored");
    pa[0] = 16'h0600; pb[0] = 16'h0200;
    pa[1] = 16'hFC00; pb[1] = 16'h0300;
    for (int i = 2; i < 5; i++) begin pa[i] = 16'h1000; pb[i] = 16'h1000; end
    applyStimulus(2, 2, 1, 2, 1'b1);
    wait_idle();

    $display("[TB] randomized commands");
    for (int c = 0; c < 30; c++) begin
      int n;
      n = (c % 7 == 0) ? 0 : $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        pa[i] = 16'($urandom);
        pb[i] = 16'($urandom);
      end
      applyStimulus(n, n, 0, $urandom_range(0, 2), (n >= 2) && ($urandom_range(0, 1) == 1));
      wait_idle();
    end

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
